// File: rtl/core_pkg.sv
// Shared pipeline encodings: writeback result-source select and memory-stage FSM states.
package core_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef enum logic {
    StIdle,
    StWait
  } mem_state_e;

endpackage

// File: rtl/dmem_access_ctrl.sv
// Data-memory handshake controller: IDLE/WAIT FSM, wait-cycle counter with timeout, and the
// sticky access-fault flag.
module dmem_access_ctrl
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_access,
  input  logic i_store,
  input  logic i_aligned,
  input  logic i_ack,
  output logic o_req,
  output logic o_stall,
  output logic o_fault,
  output logic o_bubble,
  output logic o_load_done
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  mem_state_e r_state, w_state_next;
  logic [7:0] r_wait_cnt, w_wait_cnt_next;
  logic       r_fault, w_fault_next;
  logic       w_req, w_bubble;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_fault    <= w_fault_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_fault_next    = r_fault;
    w_req           = 1'b0;
    w_bubble        = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_access && i_aligned) begin
          w_req = 1'b1;
          if (!i_ack) begin
            w_state_next    = StWait;
            w_wait_cnt_next = '0;
          end
        end else if (i_access) begin
          w_fault_next = 1'b1;
          w_bubble     = 1'b1;
        end
      end
      StWait: begin
        // Timeout abandons the access: no request, no stall, instruction retires as a bubble.
        if (r_wait_cnt == LP_TIMEOUT) begin
          w_fault_next = 1'b1;
          w_bubble     = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_req = 1'b1;
          if (i_ack) begin
            w_state_next = StIdle;
          end else begin
            w_wait_cnt_next = r_wait_cnt + 8'd1;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Gating with reset keeps the bus quiet while reset is held, even with an access presented.
  assign o_req       = reset & w_req;
  assign o_stall     = o_req & ~i_ack;
  assign o_load_done = o_req & i_ack & ~i_store;
  assign o_bubble    = w_bubble;
  assign o_fault     = r_fault;

endmodule

// File: rtl/stage_memory.sv
// Pipeline MEM stage: drives the data-memory port through dmem_access_ctrl and holds the
// MEM/WB pipeline registers.
module stage_memory
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_clear,
  input  logic        mem_reg_write,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_result_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] mem_pc_plus_4,
  input  logic [31:0] mem_imm_ext,
  input  logic [4:0]  mem_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        wb_reg_write,
  output logic [1:0]  wb_result_src,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_pc_plus_4,
  output logic [31:0] wb_imm_ext,
  output logic [4:0]  wb_rd
);

  logic w_access, w_aligned, w_bubble, w_load_done;

  assign w_access  = mem_mem_write | (mem_result_src == RES_MEM);
  assign w_aligned = (mem_alu_result[1:0] == 2'b00);

  // Upstream is frozen while stalled, so the EX/MEM values stay stable across WAIT.
  assign dmem_we    = mem_mem_write;
  assign dmem_addr  = mem_alu_result;
  assign dmem_wdata = mem_write_data;

  dmem_access_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .i_access   (w_access),
    .i_store    (mem_mem_write),
    .i_aligned  (w_aligned),
    .i_ack      (dmem_ack),
    .o_req      (dmem_req),
    .o_stall    (mem_stall),
    .o_fault    (mem_fault),
    .o_bubble   (w_bubble),
    .o_load_done(w_load_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_reg_write  <= 1'b0;
      wb_result_src <= '0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_pc_plus_4  <= '0;
      wb_imm_ext    <= '0;
      wb_rd         <= '0;
    end else if (wb_clear) begin
      wb_reg_write  <= 1'b0;
      wb_result_src <= '0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_pc_plus_4  <= '0;
      wb_imm_ext    <= '0;
      wb_rd         <= '0;
    end else if (mem_stall) begin
      wb_reg_write <= 1'b0;
    end else begin
      wb_reg_write  <= mem_reg_write & ~w_bubble;
      wb_result_src <= mem_result_src;
      wb_alu_result <= mem_alu_result;
      wb_pc_plus_4  <= mem_pc_plus_4;
      wb_imm_ext    <= mem_imm_ext;
      wb_rd         <= mem_rd;
      if (w_load_done) begin
        wb_read_data <= dmem_rdata;
      end
    end
  end

endmodule

// File: doc/stage_memory.md
STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1-255; the maximum WAIT cycles before an access is aborted.
REQ-002 SHALL have port: clk  in  1  the single rising-edge clock.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port: wb_clear  in  1  synchronous flush of the WB pipeline registers, driven by the hazard unit.
REQ-005 SHALL have ports: mem_reg_write  in  1; mem_mem_write  in  1; mem_result_src  in  2 (00 alu, 01 load data, 10 pc+4, 11 imm); all come from the EX/MEM registers.
REQ-006 SHALL have ports: mem_alu_result  in  32  (address or ALU value); mem_write_data  in  32; mem_pc_plus_4  in  32; mem_imm_ext  in  32; mem_rd  in  5.
REQ-007 SHALL have ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32; dmem_ack  in  1; dmem_rdata  in  32 (valid when dmem_ack=1).
REQ-008 SHALL have ports: mem_stall  out  1  (to hazard unit; freezes IF/ID/EX and EX/MEM); mem_fault  out  1  (sticky access fault).
REQ-009 SHALL have outputs, all registered: wb_reg_write 1, wb_result_src 2, wb_alu_result 32, wb_read_data 32, wb_pc_plus_4 32, wb_imm_ext 32, wb_rd 5.

Function
REQ-010 SHALL classify the current instruction as an access when mem_mem_write=1 or mem_result_src=01, and as a store when mem_mem_write=1.
REQ-011 SHALL implement an FSM with two states: IDLE and WAIT.
REQ-012 In IDLE, for an aligned access (mem_alu_result[1:0]=00), SHALL assert dmem_req combinationally the same cycle, with dmem_we = store, dmem_addr = mem_alu_result and dmem_wdata = mem_write_data.
REQ-013 SHALL drive mem_stall = access & aligned & ~dmem_ack, combinationally, in both states.
REQ-014 In IDLE, when the access gets dmem_ack=1 the same cycle, SHALL stay in IDLE with zero stall cycles; otherwise SHALL go to WAIT.
REQ-015 In WAIT, SHALL hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable; the inputs are stable because upstream is stalled.
REQ-016 In WAIT, on dmem_ack=1, SHALL return to IDLE, deassert mem_stall that cycle, and latch dmem_rdata into wb_read_data at the clock edge.
REQ-017 SHALL keep an 8-bit wait counter: cleared on entry to WAIT, incremented each WAIT cycle without ack.
REQ-018 When the wait counter reaches TIMEOUT_CYCLES, SHALL drop dmem_req, set mem_fault, deassert mem_stall, retire the instruction as a bubble (wb_reg_write=0) and return to IDLE.
REQ-019 For a misaligned access (mem_alu_result[1:0]!=00), SHALL issue no request and no stall, set mem_fault, and retire the instruction as a bubble.
REQ-020 While mem_stall=1, SHALL load a bubble into the WB registers (wb_reg_write=0, other fields unchanged).
REQ-021 On a non-stalled cycle, SHALL load wb_* <= mem_* values; wb_read_data SHALL load dmem_rdata only on an acked load and otherwise hold its value.
REQ-022 wb_clear=1 SHALL zero all wb_* outputs at the next edge and take priority over a normal load.
REQ-023 wb_clear=1 SHALL NOT abort an outstanding WAIT access.
REQ-024 When dmem_ack=1 arrives while no request is outstanding, SHALL ignore it.
REQ-025 Once set, mem_fault SHALL stay at 1 until reset.

Reset
REQ-026 When reset=0, SHALL asynchronously force the FSM to IDLE, the wait counter to 0, mem_fault=0 and all wb_* outputs to 0.
REQ-027 When reset is asserted mid-WAIT, SHALL drop dmem_req immediately and discard the access.
REQ-028 While reset=0, dmem_req SHALL be 0 and mem_stall SHALL be 0.

Structure
REQ-029 SHALL take the result_src encodings (RES_ALU, RES_MEM, RES_PC4, RES_IMM) and the FSM state enum from shared package core_pkg.
REQ-030 SHALL place the FSM, the wait counter and the fault logic in one sub-module, dmem_access_ctrl; the WB registers SHALL live in stage_memory.

Verification
REQ-031 Bench SHALL check: a load from 0x100 with ack in the same cycle and rdata=0xDEADBEEF gives mem_stall=0, and wb_read_data=0xDEADBEEF, wb_result_src=01, wb_reg_write=1 one edge later.
REQ-032 Bench SHALL check: a store of 0x12345678 to 0x200 with ack after 3 cycles gives mem_stall=1 for exactly 3 cycles, dmem_we/addr/wdata stable throughout, 3 bubbles in WB, and then ack releases the stall.
REQ-033 Bench SHALL check: with TIMEOUT_CYCLES=4 and no ack, dmem_req drops after 4 WAIT cycles, mem_fault=1, wb_reg_write=0, and the FSM returns to IDLE.
REQ-034 Bench SHALL check: a load from 0x103 gives no dmem_req, mem_fault=1 and a bubble in WB.
REQ-035 Bench SHALL check: reset=0 asserted during WAIT deasserts dmem_req with no clock edge, zeroes the outputs, and the next access proceeds normally.
REQ-036 Bench SHALL check: wb_clear=1 together with an ALU op (rd=5) gives wb_rd=0 and wb_reg_write=0.
